dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, number of 32-bit data words implemented; legal range 1..4093.
REQ-002 SHALL have port CLK  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port RSTn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port D_MEM_CSN  input  1  chip select, active-low; access sampled only when 0.
REQ-005 SHALL have port D_MEM_WEN  input  1  write enable, active-low; 0 = write, 1 = read.
REQ-006 SHALL have port D_MEM_ADDR  input  12  word address.
REQ-007 SHALL have port D_MEM_BE  input  4  byte-lane enables; bit i covers bits 8i+7:8i.
REQ-008 SHALL have port D_MEM_DOUT  input  32  write data from CPU.
REQ-009 SHALL have port D_MEM_DI  output  32  registered read data to CPU.
REQ-010 SHALL have port RD_VALID  output  1  high for one cycle when D_MEM_DI carries fresh read data.
REQ-011 SHALL have port OUT_PORT  output  32  memory-mapped output register.
REQ-012 SHALL have port ERR  output  1  sticky access-error flag.

Function
REQ-013 SHALL decode address map: 0..DEPTH-1 = RAM; 12'hFFD = STATUS; 12'hFFE = OUT_PORT; 12'hFFF = CYCLE counter; all other addresses = unmapped.
REQ-014 SHALL sample an access at a rising edge only when RSTn=1 and D_MEM_CSN=0; no state change from accesses otherwise.
REQ-015 SHALL for a RAM write update each lane i with D_MEM_DOUT lane i where D_MEM_BE[i]=1, leaving other lanes unchanged.
REQ-016 SHALL treat a write with D_MEM_BE=4'b0000 as a no-op (no ERR).
REQ-017 SHALL for a read register the full 32-bit word into D_MEM_DI at the sampling edge (latency 1 cycle), ignoring D_MEM_BE, and assert RD_VALID for that cycle.
REQ-018 SHALL hold D_MEM_DI unchanged and drive RD_VALID=0 after any write or idle cycle.
REQ-019 SHALL return newly written data for a read sampled the edge after a write to the same address (no stale-data hazard).
REQ-020 SHALL keep a 32-bit CYCLE counter incrementing by 1 every rising edge while RSTn=1, wrapping 32'hFFFFFFFF -> 0.
REQ-021 SHALL return for a CYCLE read the counter value held before the sampling edge; writes to CYCLE are ignored without ERR.
REQ-022 SHALL apply OUT_PORT writes per byte lane as in REQ-015; OUT_PORT reads return the current register.
REQ-023 SHALL return STATUS reads as {31'b0, ERR}; a STATUS write with D_MEM_BE[0]=1 and D_MEM_DOUT[0]=1 clears ERR; other STATUS writes ignored.
REQ-024 SHALL on any unmapped read return 32'h0 with RD_VALID=1 and set ERR; on any unmapped write leave all storage unchanged and set ERR.
REQ-025 SHALL keep ERR set until cleared per REQ-023 or reset; STATUS read in the same access that would set ERR is impossible (one access per cycle).

Reset
REQ-026 SHALL on RSTn=0, immediately and independent of CLK, force D_MEM_DI=0, RD_VALID=0, OUT_PORT=0, ERR=0, CYCLE=0.
REQ-027 SHALL not initialise RAM contents on reset; RAM retains prior contents across reset.
REQ-028 SHALL abort any access sampled in the same cycle reset asserts: no RAM or register write occurs.
REQ-029 SHALL resume counting from CYCLE=0 at the first rising edge with RSTn=1 after release.

Verification
REQ-030 SHALL cover: write addr 0x010 data 0xAABBCCDD BE=1111, then write 0x11223344 BE=0101, then read 0x010 -> D_MEM_DI=0xAA22CC44, RD_VALID=1 exactly one cycle after read edge.
REQ-031 SHALL cover: write OUT_PORT (0xFFE) 0x0000ABCD BE=0011 -> OUT_PORT=0x0000ABCD; read 0xFFE -> 0x0000ABCD.
REQ-032 SHALL cover: with DEPTH=1024 read 0x400 -> D_MEM_DI=0, ERR=1; read 0xFFD -> 0x00000001; write 0xFFD data 1 BE=0001 -> ERR=0.
REQ-033 SHALL cover: release reset, read 0xFFF at the 10th edge after release -> D_MEM_DI=9; force counter to 0xFFFFFFFF -> next value 0.
REQ-034 SHALL cover: assert RSTn=0 mid-cycle with write pending to 0xFFE -> OUT_PORT, ERR, D_MEM_DI, RD_VALID go 0 without a clock edge and OUT_PORT stays 0 after release.
REQ-035 SHALL cover: D_MEM_CSN=1 with WEN=0 addr 0x010 -> RAM word unchanged, RD_VALID=0.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-laned RAM plus STATUS / OUT_PORT / CYCLE registers
// behind a single-cycle request port with registered read data.

module dmem_lane #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int W     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ram_we,
  input  logic          out_we,
  input  logic [AW-1:0] idx,
  input  logic [W-1:0]  wbyte,
  output logic [W-1:0]  ram_byte,
  output logic [W-1:0]  out_byte
);
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] out_d, out_q;

  // RAM contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) mem[idx] <= wbyte;
  end

  assign ram_byte = mem[idx];

  always_comb begin
    out_d = out_q;
    if (out_we) out_d = wbyte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= out_d;
  end

  assign out_byte = out_q;
endmodule

module dmem_responder #(
  parameter int DEPTH = 1024
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        D_MEM_CSN,
  input  logic        D_MEM_WEN,
  input  logic [11:0] D_MEM_ADDR,
  input  logic [3:0]  D_MEM_BE,
  input  logic [31:0] D_MEM_DOUT,
  output logic [31:0] D_MEM_DI,
  output logic        RD_VALID,
  output logic [31:0] OUT_PORT,
  output logic        ERR
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [12:0] DEPTH_U  = 13'(DEPTH);
  localparam logic [11:0] A_STATUS = 12'hFFD;
  localparam logic [11:0] A_OUT    = 12'hFFE;
  localparam logic [11:0] A_CYCLE  = 12'hFFF;

  typedef struct packed {
    logic                             rd;
    logic                             wr;
    logic [11:0]                      addr;
    logic [NUM_LANES-1:0]             be;
    logic [NUM_LANES-1:0][VEC_W-1:0]  wdata;
  } req_t;

  req_t req;
  logic hit_ram, hit_stat, hit_out, hit_cyc, unmapped;
  logic [NUM_LANES-1:0]            ram_we, out_we;
  logic [NUM_LANES-1:0][VEC_W-1:0] ram_rd, out_bytes;
  logic [AW-1:0]                   idx;
  logic [31:0]                     rdata;

  logic [31:0] di_d, di_q;
  logic        rd_valid_d, rd_valid_q;
  logic        err_d, err_q;
  logic [31:0] cycle_d, cycle_q;

  // RSTn gates the request so an edge seen during reset never reaches the RAM.
  always_comb begin
    req.rd    = ~D_MEM_CSN &  D_MEM_WEN & RSTn;
    req.wr    = ~D_MEM_CSN & ~D_MEM_WEN & RSTn;
    req.addr  = D_MEM_ADDR;
    req.be    = D_MEM_BE;
    req.wdata = D_MEM_DOUT;
  end

  always_comb begin
    hit_ram  = ({1'b0, req.addr} < DEPTH_U);
    hit_stat = (req.addr == A_STATUS);
    hit_out  = (req.addr == A_OUT);
    hit_cyc  = (req.addr == A_CYCLE);
    unmapped = ~(hit_ram | hit_stat | hit_out | hit_cyc);
    idx      = req.addr[AW-1:0];
    ram_we   = {NUM_LANES{req.wr & hit_ram}} & req.be;
    out_we   = {NUM_LANES{req.wr & hit_out}} & req.be;
  end

  dmem_lane #(.DEPTH(DEPTH), .AW(AW), .W(VEC_W)) u_lane [NUM_LANES-1:0] (
    .clk      (CLK),
    .rst_n    (RSTn),
    .ram_we   (ram_we),
    .out_we   (out_we),
    .idx      (idx),
    .wbyte    (req.wdata),
    .ram_byte (ram_rd),
    .out_byte (out_bytes)
  );

  always_comb begin
    rdata = 32'h0;
    if (hit_ram)       rdata = ram_rd;
    else if (hit_stat) rdata = {31'b0, err_q};
    else if (hit_out)  rdata = out_bytes;
    else if (hit_cyc)  rdata = cycle_q;
  end

  always_comb begin
    di_d       = di_q;
    rd_valid_d = req.rd;
    cycle_d    = cycle_q + 32'd1;
    err_d      = err_q;
    if (req.rd) di_d = rdata;
    if (req.wr && hit_stat && req.be[0] && req.wdata[0][0]) err_d = 1'b0;
    // An all-lanes-off write is a no-op everywhere, so it cannot raise ERR either.
    if (unmapped && (req.rd || (req.wr && |req.be))) err_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      di_q       <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      cycle_q    <= '0;
    end else begin
      di_q       <= di_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
      cycle_q    <= cycle_d;
    end
  end

  assign D_MEM_DI = di_q;
  assign RD_VALID = rd_valid_q;
  assign OUT_PORT = out_bytes;
  assign ERR      = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table for single-cycle accesses,
// hand sequences for counter timing/wrap and asynchronous reset.

module tb_dmem_responder;
  logic        CLK = 1'b0;
  logic        RSTn;
  logic        D_MEM_CSN, D_MEM_WEN;
  logic [11:0] D_MEM_ADDR;
  logic [3:0]  D_MEM_BE;
  logic [31:0] D_MEM_DOUT;
  logic [31:0] D_MEM_DI, OUT_PORT;
  logic        RD_VALID, ERR;

  int n_chk  = 0;
  int n_pass = 0;

  dmem_responder #(.DEPTH(1024)) dut (
    .CLK(CLK), .RSTn(RSTn), .D_MEM_CSN(D_MEM_CSN), .D_MEM_WEN(D_MEM_WEN),
    .D_MEM_ADDR(D_MEM_ADDR), .D_MEM_BE(D_MEM_BE), .D_MEM_DOUT(D_MEM_DOUT),
    .D_MEM_DI(D_MEM_DI), .RD_VALID(RD_VALID), .OUT_PORT(OUT_PORT), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        csn, wen;
    logic [11:0] addr;
    logic [3:0]  be;
    logic [31:0] dout;
    logic [31:0] e_di;
    logic        e_vld;
    logic [31:0] e_out;
    logic        e_err;
  } vec_t;

  vec_t vecs [24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic csn, input logic wen, input logic [11:0] addr,
                       input logic [3:0] be, input logic [31:0] dout);
    D_MEM_CSN = csn; D_MEM_WEN = wen; D_MEM_ADDR = addr; D_MEM_BE = be; D_MEM_DOUT = dout;
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic access(input logic csn, input logic wen, input logic [11:0] addr,
                        input logic [3:0] be, input logic [31:0] dout);
    @(negedge CLK);
    drive(csn, wen, addr, be, dout);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    //           csn   wen   addr     be       dout          e_di          vld   e_out         err
    vecs[0]  = '{1'b0, 1'b0, 12'h010, 4'b1111, 32'hAABBCCDD, 32'd9,        1'b0, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 1'b0, 12'h010, 4'b0101, 32'h11223344, 32'd9,        1'b0, 32'h0,        1'b0};
    vecs[2]  = '{1'b0, 1'b1, 12'h010, 4'b0000, 32'h0,        32'hAA22CC44, 1'b1, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 1'b1, 12'h010, 4'b0000, 32'h0,        32'hAA22CC44, 1'b0, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 1'b0, 12'hFFE, 4'b0011, 32'h0000ABCD, 32'hAA22CC44, 1'b0, 32'h0000ABCD, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 12'hFFE, 4'b1111, 32'h0,        32'h0000ABCD, 1'b1, 32'h0000ABCD, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 12'hFFE, 4'b1000, 32'hFFFFFFFF, 32'h0000ABCD, 1'b0, 32'hFF00ABCD, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 12'h400, 4'b1111, 32'h0,        32'h0,        1'b1, 32'hFF00ABCD, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 12'hFFD, 4'b1111, 32'h0,        32'h1,        1'b1, 32'hFF00ABCD, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 12'hFFD, 4'b0001, 32'h0,        32'h1,        1'b0, 32'hFF00ABCD, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 12'hFFD, 4'b0001, 32'h1,        32'h1,        1'b0, 32'hFF00ABCD, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 12'hFFD, 4'b1111, 32'h0,        32'h0,        1'b1, 32'hFF00ABCD, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 12'h700, 4'b1111, 32'hFFFFFFFF, 32'h0,        1'b0, 32'hFF00ABCD, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 12'hFFD, 4'b0001, 32'h1,        32'h0,        1'b0, 32'hFF00ABCD, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 12'h010, 4'b1111, 32'h0,        32'h0,        1'b0, 32'hFF00ABCD, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 12'h010, 4'b1111, 32'h0,        32'hAA22CC44, 1'b1, 32'hFF00ABCD, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 12'h020, 4'b1111, 32'hDEADBEEF, 32'hAA22CC44, 1'b0, 32'hFF00ABCD, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 12'h020, 4'b0000, 32'h12345678, 32'hAA22CC44, 1'b0, 32'hFF00ABCD, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 12'h020, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b1, 32'hFF00ABCD, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 12'hFFF, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b0, 32'hFF00ABCD, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 12'h3FF, 4'b1111, 32'h0BADF00D, 32'hDEADBEEF, 1'b0, 32'hFF00ABCD, 1'b0};
    vecs[21] = '{1'b0, 1'b1, 12'h3FF, 4'b1111, 32'h0,        32'h0BADF00D, 1'b1, 32'hFF00ABCD, 1'b0};
    vecs[22] = '{1'b0, 1'b0, 12'hFFE, 4'b0001, 32'h000000EE, 32'h0BADF00D, 1'b0, 32'hFF00ABEE, 1'b0};
    vecs[23] = '{1'b0, 1'b1, 12'hFFE, 4'b0000, 32'h0,        32'hFF00ABEE, 1'b1, 32'hFF00ABEE, 1'b0};

    RSTn = 1'b1;
    drive(1'b1, 1'b1, 12'h0, 4'h0, 32'h0);
    #1 RSTn = 1'b0;
    #1;
    check("rst_di",  D_MEM_DI, 32'h0);
    check("rst_vld", {31'b0, RD_VALID}, 32'h0);
    check("rst_out", OUT_PORT, 32'h0);
    check("rst_err", {31'b0, ERR}, 32'h0);

    // Counter: a read sampled at the 10th edge after release returns 9.
    @(negedge CLK);
    RSTn = 1'b1;
    repeat (9) @(posedge CLK);
    access(1'b0, 1'b1, 12'hFFF, 4'hF, 32'h0);
    check("cyc10_di",  D_MEM_DI, 32'd9);
    check("cyc10_vld", {31'b0, RD_VALID}, 32'h1);

    for (int i = 0; i < 24; i++) begin
      access(vecs[i].csn, vecs[i].wen, vecs[i].addr, vecs[i].be, vecs[i].dout);
      check($sformatf("v%0d_di", i),  D_MEM_DI, vecs[i].e_di);
      check($sformatf("v%0d_vld", i), {31'b0, RD_VALID}, {31'b0, vecs[i].e_vld});
      check($sformatf("v%0d_out", i), OUT_PORT, vecs[i].e_out);
      check($sformatf("v%0d_err", i), {31'b0, ERR}, {31'b0, vecs[i].e_err});
    end

    // Counter wrap: preload all-ones, read it, then read the wrapped value.
    @(negedge CLK);
    force dut.cycle_q = 32'hFFFF_FFFF;
    drive(1'b0, 1'b1, 12'hFFF, 4'hF, 32'h0);
    #1 release dut.cycle_q;
    @(posedge CLK);
    #1;
    check("wrap_pre", D_MEM_DI, 32'hFFFF_FFFF);
    access(1'b0, 1'b1, 12'hFFF, 4'hF, 32'h0);
    check("wrap_post", D_MEM_DI, 32'h0);

    // Async reset mid-cycle with an OUT_PORT write pending.
    access(1'b0, 1'b1, 12'h400, 4'hF, 32'h0);
    access(1'b0, 1'b1, 12'h010, 4'hF, 32'h0);
    check("pre_rst_err", {31'b0, ERR}, 32'h1);
    check("pre_rst_vld", {31'b0, RD_VALID}, 32'h1);
    @(negedge CLK);
    drive(1'b0, 1'b0, 12'hFFE, 4'hF, 32'h12345678);
    #2 RSTn = 1'b0;
    #1;
    check("arst_di",  D_MEM_DI, 32'h0);
    check("arst_vld", {31'b0, RD_VALID}, 32'h0);
    check("arst_out", OUT_PORT, 32'h0);
    check("arst_err", {31'b0, ERR}, 32'h0);
    @(posedge CLK);
    #1;
    check("arst_edge_out", OUT_PORT, 32'h0);

    // First edge after release: counter reads 0, RAM survived reset.
    @(negedge CLK);
    RSTn = 1'b1;
    drive(1'b0, 1'b1, 12'hFFF, 4'hF, 32'h0);
    @(posedge CLK);
    #1;
    check("rel_cyc", D_MEM_DI, 32'h0);
    check("rel_out", OUT_PORT, 32'h0);
    access(1'b0, 1'b1, 12'h010, 4'hF, 32'h0);
    check("rel_ram", D_MEM_DI, 32'hAA22CC44);
    check("rel_vld", {31'b0, RD_VALID}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
